framebuffer_reader: RTL and testbench

FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

---
 rtl/framebuffer_reader_if.sv | 19 +
 rtl/framebuffer_reader.sv | 88 ++++++++
 tb/tb_framebuffer_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/framebuffer_reader_if.sv
// framebuffer_reader_if: burst control, RAM read port and output stream of framebuffer_reader.
interface framebuffer_reader_if #(parameter int ADDR_WIDTH = 8, parameter int DATA_WIDTH = 8);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  modport master(input start, start_addr, count, ram_dout, out_ready,
                 output busy, done, ram_en, ram_addr, out_valid, out_data, out_last);
  modport slave(output start, start_addr, count, ram_dout, out_ready,
                input busy, done, ram_en, ram_addr, out_valid, out_data, out_last);
endinterface

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: streams a burst of RAM words through a 4-entry FIFO with valid/ready output.
// Define FBR_UNDERRUN_CNT_EN to add the underrun_cnt output.
module framebuffer_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  framebuffer_reader_if.master bus
`ifdef FBR_UNDERRUN_CNT_EN
  , output logic [15:0] underrun_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d, issued_q, issued_d, popped_q, popped_d;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic pend_q, busy_q, busy_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] fifo_q [4];
  logic accept, rd_en, pop, valid;
  always_comb begin
    accept = state_q == IDLE && bus.start;
    valid = fifo_cnt_q != '0;
    // one read may be in flight, so issue only if its data is guaranteed a slot
    rd_en = state_q == RUN && issued_q != cnt_q && (fifo_cnt_q + {2'b0, pend_q}) < 3'd4;
    pop = valid && bus.out_ready;
    fifo_cnt_d = fifo_cnt_q + {2'b0, pend_q} - {2'b0, pop};
    wr_d = wr_q + {1'b0, pend_q};
    rd_d = rd_q + {1'b0, pop};
    addr_d = accept ? bus.start_addr : addr_q + {{(ADDR_WIDTH-1){1'b0}}, rd_en};
    cnt_d = accept ? bus.count : cnt_q;
    issued_d = accept ? '0 : issued_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    popped_d = accept ? '0 : popped_q + {{ADDR_WIDTH{1'b0}}, pop};
    state_d = accept ? (bus.count == '0 ? DRAIN : RUN) :
              (state_q == RUN && issued_d == cnt_q) ? DRAIN :
              (state_q == DRAIN && !pend_q && fifo_cnt_d == '0) ? IDLE : state_q;
    busy_d = state_d != IDLE;
    done_d = state_q == DRAIN && state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      issued_q <= '0;
      popped_q <= '0;
      fifo_cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      pend_q <= rd_en;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  always_ff @(posedge clk)
    if (pend_q) fifo_q[wr_q] <= bus.ram_dout;
  assign bus.ram_en = rd_en;
  assign bus.ram_addr = addr_q;
  assign bus.out_valid = valid;
  assign bus.out_data = valid ? fifo_q[rd_q] : '0;
  assign bus.out_last = valid && (popped_q + ONE) == cnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef FBR_UNDERRUN_CNT_EN
  logic [15:0] und_q, und_d;
  always_comb
    und_d = accept ? '0 :
            (busy_q && bus.out_ready && !valid && und_q != 16'hFFFF) ? und_q + 16'd1 : und_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) und_q <= '0;
    else und_q <= und_d;
  assign underrun_cnt = und_q;
`endif
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: table-driven and randomized bursts checked against an address/data reference model.
module tb_framebuffer_reader;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] ram [256];
  framebuffer_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
`ifdef FBR_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  framebuffer_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FBR_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];

  typedef struct {
    logic [7:0] a;
    int c;
    int stall;
    int exp_done;
    int exp_sr;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    chk(nm, {bus.busy, bus.done, bus.ram_en, bus.ram_addr, bus.out_valid, bus.out_last, bus.out_data}, 0);
  endtask

  // Words must appear as ram[(a+i) mod 256] for i in 0..c-1; at most 4 words may be in flight.
  task automatic run_burst(input logic [7:0] a, input int c, input int stall, input bit rnd,
                           input int exp_done, input int exp_sr);
    int reads = 0, got = 0, sr = 0, done_at = -1, first_v = -1;
    bit held = 0;
    logic [7:0] held_d = 0, ea;
    for (int t = 0; t < 3000 && done_at < 0; t++) begin
      @(negedge clk);
      bus.start = (t == 0);
      bus.start_addr = a;
      bus.count = 9'(c);
      bus.out_ready = (t < stall) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.ram_en) begin
        ea = a + 8'(reads);
        chk("ram_addr", bus.ram_addr, ea);
        reads++;
        if (t < stall) sr++;
      end
      if (held) chk("hold_data", {bus.out_valid, bus.out_data}, {1'b1, held_d});
      if (bus.out_valid) begin
        if (first_v < 0) first_v = t;
        ea = a + 8'(got);
        chk("out_data", bus.out_data, ram[ea]);
        chk("out_last", bus.out_last, got == c - 1);
      end
      chk("in_flight", (reads - got) <= 4, 1);
      held = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      if (bus.out_valid && bus.out_ready) got++;
      if (bus.done) begin
        done_at = t;
        chk("busy_at_done", bus.busy, 0);
      end
    end
    bus.start = 0;
    chk("done_seen", done_at >= 0, 1);
    chk("words", got, c);
    chk("reads", reads, c);
    if (exp_done >= 0) begin
      chk("done_cycle", done_at, exp_done);
      if (c > 0) chk("first_valid", first_v, 3);
`ifdef FBR_UNDERRUN_CNT_EN
      chk("underrun", underrun_cnt, c > 0 ? 2 : 1);
`endif
    end
    if (exp_sr >= 0) chk("stall_reads", sr, exp_sr);
    @(negedge clk);
    bus.out_ready = 1;
    #1;
    chk("done_pulse", {bus.done, bus.busy, bus.ram_en, bus.out_valid}, 0);
  endtask

  initial begin
    vec_t v[7];
    v[0] = '{8'h10, 4, 0, 7, -1};
    v[1] = '{8'hFE, 3, 0, 6, -1};
    v[2] = '{8'h20, 8, 10, -1, 4};
    v[3] = '{8'h40, 0, 0, 2, -1};
    v[4] = '{8'h00, 1, 0, 4, -1};
    v[5] = '{8'hF0, 256, 0, 259, -1};
    v[6] = '{8'hFF, 2, 0, 5, -1};
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    bus.start = 0;
    bus.start_addr = 0;
    bus.count = 0;
    bus.out_ready = 1;
    bus.ram_dout = 0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset_state");
    rst_n = 1;
    for (int i = 0; i < 7; i++) run_burst(v[i].a, v[i].c, v[i].stall, 1'b0, v[i].exp_done, v[i].exp_sr);
    // abort a 6-word burst while the third word is on the output
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus.start = (t == 0);
      bus.start_addr = 8'h30;
      bus.count = 9'd6;
      bus.out_ready = 1;
    end
    #1;
    chk("third_word", {bus.out_valid, bus.out_data}, {1'b1, ram[8'h32]});
    rst_n = 0;
    #1;
    chk_idle_outs("async_reset");
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      chk("no_done_in_reset", bus.done, 0);
    end
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("no_done_after_reset", bus.done, 0);
    run_burst(8'h50, 2, 0, 1'b0, 5, -1);
    for (int i = 0; i < 25; i++)
      run_burst(8'($urandom), (i == 24) ? 256 : int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), 1'b1, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
